// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the 32x32 register file: post-reset clear of x1..x31,
// then WB-priority arbitration against a valid/ready debug writer with a starvation guard.
module regfile_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_rd,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              pipe_stall,
  output logic              init_done,
  output logic              err_drop,
  output logic              rf_we3,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3
);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;

  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
  localparam logic [CW-1:0]     CNT_LAST  = CW'(STARVE_LIMIT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [CW-1:0]     wait_cnt;
  logic              force_slot;
  logic              wb_act, dbg_act, blocked;

  assign wb_act  = wb_we && (wb_rd != '0);
  assign dbg_act = dbg_valid && (dbg_rd != '0);

  always_comb begin
    state_nxt  = state;
    dbg_ready  = 1'b0;
    pipe_stall = 1'b1;
    init_done  = 1'b0;
    err_drop   = 1'b0;
    rf_we3     = 1'b0;
    rf_a3      = '0;
    rf_wd3     = '0;
    case (state)
      S_RESET: state_nxt = S_CLEAR;
      S_CLEAR: begin
        rf_we3 = 1'b1;
        rf_a3  = idx;
        if (idx == LAST_IDX) state_nxt = S_RUN;
      end
      S_RUN: begin
        init_done  = 1'b1;
        pipe_stall = force_slot;
        if (force_slot || !wb_act) begin
          // forced slot overrides WB; a concurrent WB write is lost and flagged
          dbg_ready = 1'b1;
          err_drop  = force_slot && wb_act;
          if (dbg_act) begin
            rf_we3 = 1'b1;
            rf_a3  = dbg_rd;
            rf_wd3 = dbg_data;
          end
        end else begin
          rf_we3 = 1'b1;
          rf_a3  = wb_rd;
          rf_wd3 = wb_data;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  assign blocked = (state == S_RUN) && dbg_valid && !dbg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_RESET;
      idx        <= ADDR_W'(1);
      wait_cnt   <= '0;
      force_slot <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= (state == S_CLEAR) ? idx + 1'b1 : ADDR_W'(1);
      force_slot <= 1'b0;
      if (blocked) begin
        if (wait_cnt == CNT_LAST) begin
          force_slot <= 1'b1;
          wait_cnt   <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sequence, WB/debug arbitration,
// starvation forced slot with drop flag, and reset during clear.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, dbg_valid;
  logic [4:0]  wb_rd, dbg_rd;
  logic [31:0] wb_data, dbg_data;
  logic        dbg_ready, pipe_stall, init_done, err_drop, rf_we3;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .dbg_ready(dbg_ready), .pipe_stall(pipe_stall), .init_done(init_done),
    .err_drop(err_drop), .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic stall, input logic rdy,
                         input logic done, input logic drop);
    chk({tag, ".stall"}, {31'd0, pipe_stall}, {31'd0, stall});
    chk({tag, ".ready"}, {31'd0, dbg_ready},  {31'd0, rdy});
    chk({tag, ".done"},  {31'd0, init_done},  {31'd0, done});
    chk({tag, ".drop"},  {31'd0, err_drop},   {31'd0, drop});
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
    chk({tag, ".we3"}, {31'd0, rf_we3}, {31'd0, we});
    chk({tag, ".a3"},  {27'd0, rf_a3},  {27'd0, a});
    chk({tag, ".wd3"}, rf_wd3, d);
  endtask

  initial begin
    rst_n = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    dbg_valid = 1'b0; dbg_rd = '0; dbg_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // RESET cycle, with WB noise that CLEAR must ignore
    #1;
    chk_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_port("reset", 1'b0, 5'd0, 32'd0);
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hFFFF_0000;

    for (int k = 1; k <= 31; k++) begin
      tick(); #1;
      chk_port($sformatf("clear%0d", k), 1'b1, 5'(k), 32'd0);
      chk_ctl($sformatf("clear%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 31) wb_we = 1'b0;
    end

    tick(); #1;
    chk_ctl("run_entry", 1'b0, 1'b1, 1'b1, 1'b0);
    chk_port("run_entry", 1'b0, 5'd0, 32'd0);

    // WB write is combinational; x0 is suppressed
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; #1;
    chk_port("wb_x5", 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("wb_x5.ready", {31'd0, dbg_ready}, 32'd0);
    wb_rd = 5'd0; #1;
    chk_port("wb_x0", 1'b0, 5'd0, 32'd0);

    // debug write with WB idle
    wb_we = 1'b0; dbg_valid = 1'b1; dbg_rd = 5'd7; dbg_data = 32'h12; #1;
    chk_ctl("dbg_x7", 1'b0, 1'b1, 1'b1, 1'b0);
    chk_port("dbg_x7", 1'b1, 5'd7, 32'h12);
    tick();

    // debug to x0: accepted, no write
    dbg_rd = 5'd0; dbg_data = 32'h99; #1;
    chk("dbg_x0.ready", {31'd0, dbg_ready}, 32'd1);
    chk_port("dbg_x0", 1'b0, 5'd0, 32'd0);
    tick();
    dbg_valid = 1'b0;

    // starvation: 4 blocked cycles, then forced slot dropping WB x3
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hAAAA_5555;
    dbg_valid = 1'b1; dbg_rd = 5'd9; dbg_data = 32'h55;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk_ctl($sformatf("starve%0d", c), 1'b0, 1'b0, 1'b1, 1'b0);
      chk_port($sformatf("starve%0d", c), 1'b1, 5'd3, 32'hAAAA_5555);
      tick();
    end
    #1;
    chk_ctl("forced", 1'b1, 1'b1, 1'b1, 1'b1);
    chk_port("forced", 1'b1, 5'd9, 32'h55);
    tick();
    dbg_valid = 1'b0; #1;
    chk_ctl("after_force", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_port("after_force", 1'b1, 5'd3, 32'hAAAA_5555);

    // dropping dbg_valid clears the wait count: 2 blocked, gap, then 4 more blocked
    dbg_valid = 1'b1;
    tick(); tick();
    dbg_valid = 1'b0;
    tick();
    dbg_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk_ctl($sformatf("rewait%0d", c), 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    #1;
    chk_ctl("reforced", 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    dbg_valid = 1'b0; wb_we = 1'b0;

    // reset mid-RUN, then reset mid-CLEAR at idx=10 with a pending debug request
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; dbg_valid = 1'b1; dbg_rd = 5'd12; dbg_data = 32'h77; #1;
    chk_ctl("reset2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_port("reset2", 1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick(); #1;
      chk_port($sformatf("clr2_%0d", k), 1'b1, 5'(k), 32'd0);
      chk("clr2.ready", {31'd0, dbg_ready}, 32'd0);
    end
    rst_n = 1'b0;
    tick(); #1;
    chk_ctl("reset3", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_port("reset3", 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    tick(); #1;
    chk_port("restart", 1'b1, 5'd1, 32'd0);
    chk_ctl("restart", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
